// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter: grant encoding,
// read latency as seen by requesters, and the grant-counter helper.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } grant_e;

    // Issue cycle to ValidX: one RAM cycle plus the output register.
    localparam int RD_LATENCY = 2;
    localparam int CNT_WIDTH  = 16;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester A/B and RAM-side signals for ram_arbiter.
// Handshake: ReqX is held with Write/Addr/Input stable until AckX is seen high
// in a cycle; the request is issued to RAM in that same cycle. ValidX is a
// single-cycle pulse marking OutputX as fresh read data; it has no back-pressure.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);

    logic                  ReqA;
    logic                  WriteA;
    logic [ADDR_WIDTH-1:0] AddrA;
    logic [DATA_WIDTH-1:0] InputA;
    logic                  AckA;
    logic [DATA_WIDTH-1:0] OutputA;
    logic                  ValidA;

    logic                  ReqB;
    logic                  WriteB;
    logic [ADDR_WIDTH-1:0] AddrB;
    logic [DATA_WIDTH-1:0] InputB;
    logic                  AckB;
    logic [DATA_WIDTH-1:0] OutputB;
    logic                  ValidB;

    logic [ADDR_WIDTH-1:0] RamAddr;
    logic                  RamWrite;
    logic [DATA_WIDTH-1:0] RamInput;
    logic [DATA_WIDTH-1:0] RamOutput;

    // Environment side: requesters plus the external RAM.
    modport master (
        output ReqA, WriteA, AddrA, InputA,
        input  AckA, OutputA, ValidA,
        output ReqB, WriteB, AddrB, InputB,
        input  AckB, OutputB, ValidB,
        input  RamAddr, RamWrite, RamInput,
        output RamOutput
    );

    modport slave (
        input  ReqA, WriteA, AddrA, InputA,
        output AckA, OutputA, ValidA,
        input  ReqB, WriteB, AddrB, InputB,
        output AckB, OutputB, ValidB,
        output RamAddr, RamWrite, RamInput,
        input  RamOutput
    );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not granted most recently.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic   ReqA,
    input  logic   ReqB,
    input  grant_e LastGrant,
    output grant_e Grant
);

    always_comb begin
        Grant = GRANT_NONE;
        if (ReqA && ReqB) begin
            Grant = (LastGrant == GRANT_A) ? GRANT_B : GRANT_A;
        end else if (ReqA) begin
            Grant = GRANT_A;
        end else if (ReqB) begin
            Grant = GRANT_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one external synchronous RAM between requesters A and B.
// Define RAM_ARB_STATS_EN to add saturating per-requester grant counters (GrantCntA/B).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    ram_arbiter_if.slave bus
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] GrantCntA,
    output logic [CNT_WIDTH-1:0] GrantCntB
`endif
);

    grant_e                rr_grant;
    grant_e                grant;
    grant_e                last_grant_q, last_grant_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_sel_b_q, rd_sel_b_d;
    logic                  valid_a_q, valid_a_d;
    logic                  valid_b_q, valid_b_d;
    logic [DATA_WIDTH-1:0] out_a_q, out_a_d;
    logic [DATA_WIDTH-1:0] out_b_q, out_b_d;

    logic                  ack_a, ack_b;
    logic                  ram_write;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_input;

    ram_arb_rr u_rr (
        .ReqA      (bus.ReqA),
        .ReqB      (bus.ReqB),
        .LastGrant (last_grant_q),
        .Grant     (rr_grant)
    );

    // Masking with Reset_n keeps Ack and the RAM side at 0 throughout reset.
    assign grant = Reset_n ? rr_grant : GRANT_NONE;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_grant_q <= GRANT_B;
            rd_pend_q    <= 1'b0;
            rd_sel_b_q   <= 1'b0;
            valid_a_q    <= 1'b0;
            valid_b_q    <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_sel_b_q   <= rd_sel_b_d;
            valid_a_q    <= valid_a_d;
            valid_b_q    <= valid_b_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
        end
    end

    // rd_pend marks the cycle in which RamOutput carries the previous read's data.
    always_comb begin
        last_grant_d = (grant == GRANT_NONE) ? last_grant_q : grant;
        rd_pend_d    = ((grant == GRANT_A) && !bus.WriteA) ||
                       ((grant == GRANT_B) && !bus.WriteB);
        rd_sel_b_d   = (grant == GRANT_B);
        valid_a_d    = rd_pend_q && !rd_sel_b_q;
        valid_b_d    = rd_pend_q && rd_sel_b_q;
        out_a_d      = valid_a_d ? bus.RamOutput : out_a_q;
        out_b_d      = valid_b_d ? bus.RamOutput : out_b_q;
    end

    always_comb begin
        ack_a     = 1'b0;
        ack_b     = 1'b0;
        ram_write = 1'b0;
        ram_addr  = '0;
        ram_input = '0;
        case (grant)
            GRANT_A: begin
                ack_a     = 1'b1;
                ram_write = bus.WriteA;
                ram_addr  = bus.AddrA;
                ram_input = bus.InputA;
            end
            GRANT_B: begin
                ack_b     = 1'b1;
                ram_write = bus.WriteB;
                ram_addr  = bus.AddrB;
                ram_input = bus.InputB;
            end
            default: ;
        endcase
    end

    assign bus.AckA     = ack_a;
    assign bus.AckB     = ack_b;
    assign bus.RamWrite = ram_write;
    assign bus.RamAddr  = ram_addr;
    assign bus.RamInput = ram_input;
    assign bus.ValidA   = valid_a_q;
    assign bus.ValidB   = valid_b_q;
    assign bus.OutputA  = out_a_q;
    assign bus.OutputB  = out_b_q;

`ifdef RAM_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] grant_cnt_a_q, grant_cnt_a_d;
    logic [CNT_WIDTH-1:0] grant_cnt_b_q, grant_cnt_b_d;

    assign grant_cnt_a_d = ack_a ? sat_inc(grant_cnt_a_q) : grant_cnt_a_q;
    assign grant_cnt_b_d = ack_b ? sat_inc(grant_cnt_b_q) : grant_cnt_b_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            grant_cnt_a_q <= '0;
            grant_cnt_b_q <= '0;
        end else begin
            grant_cnt_a_q <= grant_cnt_a_d;
            grant_cnt_b_q <= grant_cnt_b_d;
        end
    end

    assign GrantCntA = grant_cnt_a_q;
    assign GrantCntB = grant_cnt_b_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: external RAM model, random and directed requesters,
// a reference arbitration/memory model feeding per-requester expected queues.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- DUT and external RAM ----------------
    ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef RAM_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] grant_cnt_a, grant_cnt_b;
`endif

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
`ifdef RAM_ARB_STATS_EN
        ,
        .GrantCntA (grant_cnt_a),
        .GrantCntB (grant_cnt_b)
`endif
    );

    logic [DW-1:0] ram_mem [2**AW];
    logic [DW-1:0] ram_q;

    always @(posedge clk) begin
        if (bus.RamWrite) ram_mem[bus.RamAddr] <= bus.RamInput;
        ram_q <= ram_mem[bus.RamAddr];
    end
    assign bus.RamOutput = ram_q;

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard queues ----------------
    grant_e        m_last = GRANT_B;
    logic [DW-1:0] m_mem [2**AW];
    logic [DW-1:0] exp_a_q[$], exp_b_q[$];
    int            due_a_q[$], due_b_q[$];
    bit            exp_ga, exp_gb, exp_w;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    logic [15:0]   m_cnt_a = '0, m_cnt_b = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ack",   {30'd0, bus.AckA, bus.AckB}, 0);
            chk("rst_valid", {30'd0, bus.ValidA, bus.ValidB}, 0);
            chk("rst_out",   {16'd0, bus.OutputA, bus.OutputB}, 0);
            chk("rst_ram",   {15'd0, bus.RamWrite, bus.RamAddr, bus.RamInput}, 0);
            m_last = GRANT_B;
            exp_a_q.delete(); exp_b_q.delete();
            due_a_q.delete(); due_b_q.delete();
            m_cnt_a = '0; m_cnt_b = '0;
        end else begin
            // Lone request wins; on a tie the side not served last wins.
            exp_ga = bus.ReqA && (!bus.ReqB || m_last != GRANT_A);
            exp_gb = bus.ReqB && !exp_ga;
            exp_w = 1'b0; exp_addr = '0; exp_din = '0;
            if (exp_ga) begin
                exp_w = bus.WriteA; exp_addr = bus.AddrA; exp_din = bus.InputA;
            end else if (exp_gb) begin
                exp_w = bus.WriteB; exp_addr = bus.AddrB; exp_din = bus.InputB;
            end
            chk("ack_a", {31'd0, bus.AckA}, {31'd0, exp_ga});
            chk("ack_b", {31'd0, bus.AckB}, {31'd0, exp_gb});
            chk("ram_side", {15'd0, bus.RamWrite, bus.RamAddr, bus.RamInput},
                {15'd0, exp_w, exp_addr, exp_din});
            if (exp_ga || exp_gb) begin
                m_last = exp_ga ? GRANT_A : GRANT_B;
                if (exp_w) begin
                    m_mem[exp_addr] = exp_din;
                end else if (exp_ga) begin
                    exp_a_q.push_back(m_mem[exp_addr]); due_a_q.push_back(cyc + RD_LATENCY);
                end else begin
                    exp_b_q.push_back(m_mem[exp_addr]); due_b_q.push_back(cyc + RD_LATENCY);
                end
            end
`ifdef RAM_ARB_STATS_EN
            chk("cnt_a_track", {16'd0, grant_cnt_a}, {16'd0, m_cnt_a});
            chk("cnt_b_track", {16'd0, grant_cnt_b}, {16'd0, m_cnt_b});
            if (exp_ga && m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
            if (exp_gb && m_cnt_b != 16'hFFFF) m_cnt_b = m_cnt_b + 16'd1;
`endif
        end
    end

    // ---------------- monitor ----------------
    logic [DW-1:0] out_a_m = '0, out_b_m = '0;
    bit            ev_a, ev_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            out_a_m = '0;
            out_b_m = '0;
        end else begin
            ev_a = (due_a_q.size() > 0) && (due_a_q[0] == cyc);
            ev_b = (due_b_q.size() > 0) && (due_b_q[0] == cyc);
            chk("valid_a", {31'd0, bus.ValidA}, {31'd0, ev_a});
            chk("valid_b", {31'd0, bus.ValidB}, {31'd0, ev_b});
            if (ev_a) begin
                out_a_m = exp_a_q.pop_front();
                void'(due_a_q.pop_front());
            end
            if (ev_b) begin
                out_b_m = exp_b_q.pop_front();
                void'(due_b_q.pop_front());
            end
            chk("output_a", {24'd0, bus.OutputA}, {24'd0, out_a_m});
            chk("output_b", {24'd0, bus.OutputB}, {24'd0, out_b_m});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit b, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (b) begin
            bus.ReqB = 1'b1; bus.WriteB = w; bus.AddrB = a; bus.InputB = d;
        end else begin
            bus.ReqA = 1'b1; bus.WriteA = w; bus.AddrA = a; bus.InputA = d;
        end
    endtask

    task automatic idle(input bit b);
        if (b) begin
            bus.ReqB = 1'b0; bus.WriteB = 1'b0; bus.AddrB = '0; bus.InputB = '0;
        end else begin
            bus.ReqA = 1'b0; bus.WriteA = 1'b0; bus.AddrA = '0; bus.InputA = '0;
        end
    endtask

    // hold=1: keep the request until Ack; hold=0: offer it for one cycle only.
    task automatic do_req(input bit b, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit hold);
        bit acked = 1'b0;
        int n = 0;
        drive(b, w, a, d);
        while (!acked && n < 64) begin
            @(negedge clk);
            acked = b ? bus.AckB : bus.AckA;
            n++;
            if (!hold) break;
        end
        step();
        if (hold) chk(b ? "ack_wait_b" : "ack_wait_a", {31'd0, acked}, 1);
    endtask

    task automatic do_reset();
        idle(0); idle(1);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic rand_requester(input bit b, input int ops);
        for (int i = 0; i < ops; i++) begin
            do_req(b, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                   DW'($urandom), ($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 2) != 0) begin
                idle(b);
                repeat ($urandom_range(1, 2)) step();
            end
        end
        idle(b);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle(0); idle(1);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Write then read the same address from A.
        do_req(0, 1'b1, 8'd0, 8'd42, 1'b1);
        do_req(0, 1'b0, 8'd0, 8'd0, 1'b1);
        idle(0);
        repeat (3) step();
        chk("wr_rd_addr0", {24'd0, bus.OutputA}, 32'd42);

        // Read immediately following a write to the same location.
        do_req(0, 1'b1, 8'd5, 8'hAA, 1'b1);
        do_req(0, 1'b0, 8'd5, 8'd0, 1'b1);
        idle(0);
        repeat (3) step();
        chk("wr_rd_addr5", {24'd0, bus.OutputA}, 32'hAA);

        // Both requesters held continuously from reset: strict alternation.
        do_reset();
        fork
            begin
                for (int i = 0; i < 20; i++) do_req(0, 1'b1, AW'(100 + i), DW'(i), 1'b1);
                idle(0);
            end
            begin
                for (int i = 0; i < 20; i++) do_req(1, 1'b1, AW'(150 + i), DW'(8'h80 + i), 1'b1);
                idle(1);
            end
        join
        for (int i = 0; i < 20; i++) do_req(0, 1'b0, AW'(100 + i), 8'd0, 1'b1);
        for (int i = 0; i < 20; i++) do_req(1, 1'b0, AW'(150 + i), 8'd0, 1'b1);
        idle(0); idle(1);
        repeat (3) step();

        // Fill 0..99 with data=address, then read it back from both sides at once.
        for (int i = 0; i < 100; i++) do_req(0, 1'b1, AW'(i), DW'(i), 1'b1);
        fork
            begin
                for (int i = 0; i < 100; i++) do_req(0, 1'b0, AW'(i), 8'd0, 1'b1);
                idle(0);
            end
            begin
                for (int i = 0; i < 100; i++) do_req(1, 1'b0, AW'(i), 8'd0, 1'b1);
                idle(1);
            end
        join
        repeat (3) step();
        chk("fill_last_a", {24'd0, bus.OutputA}, 32'd99);
        chk("fill_last_b", {24'd0, bus.OutputB}, 32'd99);

        // Reset asserted the cycle after a read Ack: the read must vanish.
        do_req(0, 1'b0, 8'd7, 8'd0, 1'b1);
        rst_n = 1'b0;
        idle(0);
        repeat (2) step();
        drive(0, 1'b0, 8'd1, 8'd0);
        drive(1, 1'b0, 8'd2, 8'd0);
        step();
        rst_n = 1'b1;
        fork
            do_req(0, 1'b0, 8'd1, 8'd0, 1'b1);
            do_req(1, 1'b0, 8'd2, 8'd0, 1'b1);
            begin
                @(negedge clk);
                chk("tie_after_reset", {30'd0, bus.AckA, bus.AckB}, 32'b10);
            end
        join
        idle(0); idle(1);
        repeat (4) step();

        // Random traffic with occasional withdrawn requests and idle gaps.
        fork
            rand_requester(0, 200);
            rand_requester(1, 200);
        join
        repeat (4) step();

`ifdef RAM_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) do_req(0, 1'b1, AW'(200 + i), DW'(i), 1'b1);
        idle(0);
        for (int i = 0; i < 5; i++) do_req(1, 1'b1, AW'(210 + i), DW'(i), 1'b1);
        idle(1);
        step();
        chk("cnt_a_3", {16'd0, grant_cnt_a}, 32'd3);
        chk("cnt_b_5", {16'd0, grant_cnt_b}, 32'd5);
        force dut.grant_cnt_a_q = 16'hFFFF;
        m_cnt_a = 16'hFFFF;
        #1;
        release dut.grant_cnt_a_q;
        step();
        do_req(0, 1'b1, 8'd220, 8'd1, 1'b1);
        idle(0);
        step();
        chk("cnt_a_sat", {16'd0, grant_cnt_a}, 32'hFFFF);
`endif

        repeat (4) step();
        chk("drain", due_a_q.size() + due_b_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning RAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning RAM address width.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: Clk  in  1  sole clock, rising-edge; Reset_n  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have per requester X in {A,B}: ReqX  in  1  access request, held until AckX.
REQ-005 The block SHALL have WriteX  in  1  1=write, 0=read, qualified by ReqX.
REQ-006 The block SHALL have AddrX  in  ADDR_WIDTH  access address.
REQ-007 The block SHALL have InputX  in  DATA_WIDTH  write data.
REQ-008 The block SHALL have AckX  out  1  one-cycle pulse in the cycle the request is issued to RAM.
REQ-009 The block SHALL have OutputX  out  DATA_WIDTH  registered read data.
REQ-010 The block SHALL have ValidX  out  1  one-cycle pulse, OutputX valid.
REQ-011 The block SHALL have RAM side ports: RamAddr  out  ADDR_WIDTH; RamWrite  out  1; RamInput  out  DATA_WIDTH; RamOutput  in  DATA_WIDTH (RAM read data, valid one cycle after address sampled).

Function
REQ-012 In each cycle the block SHALL issue at most one request, combinationally driving RamAddr/RamWrite/RamInput from the granted requester and pulsing its AckX in the same cycle.
REQ-013 When only one ReqX is high, that requester SHALL be granted.
REQ-014 When both are high, the grant SHALL go to the requester not granted most recently (round-robin); the LastGrant register resets to B, so A wins the first tie.
REQ-015 LastGrant SHALL update only on a grant; idle cycles do not change it.
REQ-016 With no grant, RamWrite, RamAddr and RamInput SHALL be 0.
REQ-017 A read issued in cycle N SHALL capture RamOutput at the end of cycle N+1 into OutputX, with ValidX high in cycle N+2 (latency 2).
REQ-018 Reads SHALL be pipelined: back-to-back reads every cycle, from either or alternating requesters, each return in order with the correct ValidX.
REQ-019 OutputX SHALL hold its value until the next read for X completes.
REQ-020 A write in cycle N followed by a read of the same address in cycle N+1 SHALL return the written data.
REQ-021 Writes SHALL produce no ValidX.
REQ-022 A requester dropping ReqX before AckX SHALL be treated as withdrawn, with no error.

Reset
REQ-023 On Reset_n low, all Ack/Valid outputs, OutputA/B and the RAM-side outputs SHALL go to 0, LastGrant SHALL go to B, and the read pipeline SHALL be cleared asynchronously.
REQ-024 A read in flight when reset asserts SHALL be discarded, with no ValidX after release.
REQ-025 The first grant SHALL be possible in the first cycle after Reset_n rises.

Configuration
REQ-026 Macro RAM_ARB_STATS_EN defined SHALL add outputs GrantCntA and GrantCntB (16-bit, saturating at 16'hFFFF, incremented on each AckX, reset to 0).
REQ-027 With RAM_ARB_STATS_EN undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Package ram_arb_pkg SHALL hold the grant enum (GRANT_NONE, GRANT_A, GRANT_B), the read-latency constant (2) and the counter width (16).
REQ-029 The two-way round-robin picker SHALL be sub-module ram_arb_rr (inputs ReqA, ReqB, LastGrant; output grant enum; combinational).
REQ-030 The RAM SHALL be external; the bench SHALL instantiate RAM with matching parameters.

Verification
REQ-031 ReqA write Addr=0 Input=42, then ReqA read Addr=0 -> AckA each cycle; ValidA two cycles after the read Ack with OutputA=42.
REQ-032 ReqA and ReqB held high continuously after reset -> Ack order A,B,A,B...; RAM writes interleave with no lost request.
REQ-033 A writes i=0..99 (Addr=i, Input=i), then A and B both read 0..99 concurrently -> every ValidA/ValidB returns data=address, in issue order, with no gaps while requests are pending.
REQ-034 Write Addr=5 Input=8'hAA in cycle N, read Addr=5 in N+1 -> Output=8'hAA.
REQ-035 Issue a read, assert Reset_n low in the cycle after Ack, then release -> no ValidX; all outputs 0; first tie after release granted to A.
REQ-036 With RAM_ARB_STATS_EN: 3 A grants and 5 B grants -> GrantCntA=3, GrantCntB=5; force GrantCntA to 16'hFFFF, then one more grant -> it stays 16'hFFFF.
